// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: arbitrates exceptions/interrupts/MRET, strobes CSR file, drains core.
// Optional macro IRQ_SYNC_EN adds 2-flop synchronizers on the interrupt lines.
`ifndef MXLEN
`define MXLEN 32
`endif

module trap_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_code,
  input  logic              mret_req,
  input  logic              instr_boundary,
  input  logic              mstatus_mie,
  input  logic [2:0]        mie_bits,
  input  logic              irq_ext,
  input  logic              irq_timer,
  input  logic              irq_soft,
  output logic              exception,
  output logic              mret,
  output logic              csr_read,
  output logic [`MXLEN-1:0] exception_num,
  output logic              pc_load,
  output logic              stall,
  output logic              flush
);

  typedef enum logic [1:0] {RUN, ENTER, RET, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             irq_ext_s, irq_timer_s, irq_soft_s;
  logic             irq_ok, take_mei, take_msi, take_mti, take_irq;
  logic [3:0]       irq_code;

`ifdef IRQ_SYNC_EN
  logic [2:0] irq_meta, irq_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= {irq_ext, irq_timer, irq_soft};
      irq_sync <= irq_meta;
    end
  end

  assign {irq_ext_s, irq_timer_s, irq_soft_s} = irq_sync;
`else
  assign {irq_ext_s, irq_timer_s, irq_soft_s} = {irq_ext, irq_timer, irq_soft};
`endif

  // mie_bits = {MEIE, MTIE, MSIE}; a sync exception always wins over interrupts
  assign irq_ok   = mstatus_mie & instr_boundary & ~ex_valid;
  assign take_mei = irq_ok & mie_bits[2] & irq_ext_s;
  assign take_msi = irq_ok & mie_bits[0] & irq_soft_s;
  assign take_mti = irq_ok & mie_bits[1] & irq_timer_s;
  assign take_irq = take_mei | take_msi | take_mti;

  always_comb begin
    irq_code = 4'd7;
    if (take_mei)      irq_code = 4'd11;
    else if (take_msi) irq_code = 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      exception_num <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        RUN: begin
          if (ex_valid)
            exception_num <= {1'b0, {(`MXLEN-6){1'b0}}, ex_code};
          else if (take_irq)
            exception_num <= {1'b1, {(`MXLEN-5){1'b0}}, irq_code};
        end
        ENTER, RET: cnt <= CNT_W'(FLUSH_CYCLES);
        DRAIN:      cnt <= cnt - CNT_W'(1);
        default:    cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ex_valid || take_irq) state_nxt = ENTER;
        else if (mret_req)        state_nxt = RET;
      end
      ENTER, RET: state_nxt = DRAIN;
      DRAIN:      if (cnt <= CNT_W'(1)) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  always_comb begin
    exception = 1'b0;
    mret      = 1'b0;
    csr_read  = 1'b0;
    pc_load   = 1'b0;
    flush     = 1'b0;
    stall     = 1'b0;
    case (state)
      ENTER: begin
        exception = 1'b1;
        csr_read  = 1'b1;
        pc_load   = 1'b1;
        flush     = 1'b1;
        stall     = 1'b1;
      end
      RET: begin
        mret     = 1'b1;
        csr_read = 1'b1;
        pc_load  = 1'b1;
        flush    = 1'b1;
        stall    = 1'b1;
      end
      DRAIN:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl.
`ifndef MXLEN
`define MXLEN 32
`endif

module tb_trap_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ex_valid = 1'b0;
  logic [4:0]        ex_code = '0;
  logic              mret_req = 1'b0;
  logic              instr_boundary = 1'b0;
  logic              mstatus_mie = 1'b0;
  logic [2:0]        mie_bits = '0;
  logic              irq_ext = 1'b0;
  logic              irq_timer = 1'b0;
  logic              irq_soft = 1'b0;
  logic              exception, mret, csr_read, pc_load, stall, flush;
  logic [`MXLEN-1:0] exception_num;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  trap_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_code(ex_code), .mret_req(mret_req),
    .instr_boundary(instr_boundary), .mstatus_mie(mstatus_mie), .mie_bits(mie_bits),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .exception(exception), .mret(mret), .csr_read(csr_read), .exception_num(exception_num),
    .pc_load(pc_load), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: stall=%b after %0d cycles, required 0", stall, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({exception, mret, csr_read, pc_load, stall, flush} !== 6'b0 || exception_num !== '0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%b num=%h, required 0", {exception, mret, csr_read, pc_load, stall, flush}, exception_num);
    end
    rst = 1'b0;
    ex_valid = 1'b1;
    ex_code = 5'd5;
    @(posedge clk);
    #2;
    checks++;
    if (exception !== 1'b1 || exception_num !== 32'h5) begin
      errors++;
      $display("FAIL pre_reset_enter: exception=%b num=%h, required 1/00000005", exception, exception_num);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (exception !== 1'b0 || stall !== 1'b0 || flush !== 1'b0 || exception_num !== '0) begin
      errors++;
      $display("FAIL async_reset: exception=%b stall=%b flush=%b num=%h, required 0", exception, stall, flush, exception_num);
    end
    @(negedge clk);
    rst = 1'b0;
    ex_valid = 1'b0;
    step();
    checks++;
    if (stall !== 1'b0 || exception !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run: stall=%b exception=%b, required 0/0", stall, exception);
    end
  endtask

  task automatic test_sync_exception();
    int n = 0;
    ex_valid = 1'b1;
    ex_code = 5'd2;
    step();
    ex_valid = 1'b0;
    checks++;
    if (exception !== 1'b1 || mret !== 1'b0 || csr_read !== 1'b1 || pc_load !== 1'b1 ||
        flush !== 1'b1 || exception_num !== 32'h2) begin
      errors++;
      $display("FAIL sync_exc_strobe: exc=%b mret=%b rd=%b pcl=%b fl=%b num=%h, required 1/0/1/1/1/00000002",
               exception, mret, csr_read, pc_load, flush, exception_num);
    end
    while (stall && n < 20) begin
      n++;
      step();
      if (stall && (exception || flush || csr_read)) begin
        checks++;
        errors++;
        $display("FAIL drain_strobes: exc=%b flush=%b rd=%b in drain, required 0", exception, flush, csr_read);
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL sync_exc_stall_len: got %0d cycles, required 4", n);
    end
  endtask

  task automatic test_irq_priority();
    int n = 0;
    mstatus_mie = 1'b1;
    mie_bits = 3'b111;
    instr_boundary = 1'b1;
    irq_ext = 1'b1;
    irq_timer = 1'b1;
    while (!exception && n < 10) begin step(); n++; end
    irq_ext = 1'b0;
    checks++;
    if (exception !== 1'b1 || exception_num !== 32'h8000_000B) begin
      errors++;
      $display("FAIL mei_priority: exc=%b num=%h, required 1/8000000b", exception, exception_num);
    end
    step();
    n = 0;
    while (!exception && n < 10) begin step(); n++; end
    irq_timer = 1'b0;
    checks++;
    if (exception !== 1'b1 || exception_num !== 32'h8000_0007) begin
      errors++;
      $display("FAIL mti_after_drain: exc=%b num=%h, required 1/80000007", exception, exception_num);
    end
    wait_idle();
    repeat (3) step();
  endtask

  task automatic test_mie_masked();
    int n = 0;
    int seen = 0;
    mstatus_mie = 1'b0;
    mie_bits = 3'b111;
    instr_boundary = 1'b1;
    irq_soft = 1'b1;
    repeat (20) begin
      step();
      if (exception) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mie_masked: %0d exceptions while mstatus_mie=0, required 0", seen);
    end
    mstatus_mie = 1'b1;
    while (!exception && n < 10) begin step(); n++; end
    irq_soft = 1'b0;
    mstatus_mie = 1'b0;
    checks++;
    if (exception !== 1'b1 || exception_num !== 32'h8000_0003) begin
      errors++;
      $display("FAIL msi_taken: exc=%b num=%h, required 1/80000003", exception, exception_num);
    end
    wait_idle();
    repeat (3) step();
  endtask

  task automatic test_gating();
    int seen = 0;
    mstatus_mie = 1'b1;
    mie_bits = 3'b111;
    instr_boundary = 1'b0;
    irq_ext = 1'b1;
    repeat (8) begin step(); if (exception) seen++; end
    irq_ext = 1'b0;
    repeat (4) step();
    instr_boundary = 1'b1;
    mie_bits = 3'b010;
    irq_ext = 1'b1;
    irq_soft = 1'b1;
    repeat (8) begin step(); if (exception) seen++; end
    irq_ext = 1'b0;
    irq_soft = 1'b0;
    repeat (4) step();
    mie_bits = 3'b111;
    #1 irq_soft = 1'b1;
    #2 irq_soft = 1'b0;
    repeat (6) begin step(); if (exception) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL irq_gating: %0d unexpected exceptions, required 0", seen);
    end
    mstatus_mie = 1'b0;
  endtask

  task automatic test_ex_vs_mret();
    int n = 0;
    ex_valid = 1'b1;
    ex_code = 5'd4;
    mret_req = 1'b1;
    step();
    ex_valid = 1'b0;
    mret_req = 1'b0;
    checks++;
    if (exception !== 1'b1 || mret !== 1'b0 || exception_num !== 32'h4) begin
      errors++;
      $display("FAIL ex_beats_mret: exc=%b mret=%b num=%h, required 1/0/00000004", exception, mret, exception_num);
    end
    wait_idle();
    step();
    checks++;
    if (mret !== 1'b0) begin
      errors++;
      $display("FAIL mret_dropped: mret=%b, required 0", mret);
    end
    mret_req = 1'b1;
    step();
    mret_req = 1'b0;
    checks++;
    if (mret !== 1'b1 || exception !== 1'b0 || csr_read !== 1'b1 || pc_load !== 1'b1 ||
        flush !== 1'b1 || exception_num !== 32'h4) begin
      errors++;
      $display("FAIL mret_strobe: mret=%b exc=%b rd=%b pcl=%b fl=%b num=%h, required 1/0/1/1/1/00000004",
               mret, exception, csr_read, pc_load, flush, exception_num);
    end
    while (stall && n < 20) begin n++; step(); end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL mret_stall_len: got %0d cycles, required 4", n);
    end
  endtask

  task automatic test_drain_ignore();
    int seen = 0;
    ex_valid = 1'b1;
    ex_code = 5'd1;
    step();
    ex_code = 5'd9;
    step();
    step();
    step();
    ex_valid = 1'b0;
    repeat (6) begin step(); if (exception) seen++; end
    checks++;
    if (seen !== 0 || exception_num !== 32'h1) begin
      errors++;
      $display("FAIL drain_ignore: %0d exceptions num=%h, required 0/00000001", seen, exception_num);
    end
  endtask

  task automatic test_irq_latency();
    int n = 0;
    mstatus_mie = 1'b1;
    mie_bits = 3'b010;
    instr_boundary = 1'b1;
    irq_timer = 1'b1;
    while (!exception && n < 10) begin step(); n++; end
    irq_timer = 1'b0;
    checks++;
    if (n !== IRQ_LAT || exception_num !== 32'h8000_0007) begin
      errors++;
      $display("FAIL irq_latency: got %0d cycles num=%h, required %0d/80000007", n, exception_num, IRQ_LAT);
    end
    wait_idle();
    mstatus_mie = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sync_exception();
    test_irq_priority();
    test_mie_masked();
    test_gating();
    test_ex_vs_mret();
    test_drain_ignore();
    test_irq_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
